// File: rtl/mem_bus_arbiter_pkg.sv
// Shared IDs and default sizing for the fetch/LSU memory-port arbiter.
package mem_bus_arbiter_pkg;
   localparam int ARB_AW         = 32;
   localparam int ARB_DW         = 32;
   localparam int ARB_OUTS_DEPTH = 4;
   localparam int ARB_MAX_WAIT   = 8;
   localparam int ARB_ID_W       = 1;

   typedef logic [ARB_ID_W-1:0] arb_id_t;

   localparam arb_id_t ARB_ID_IFU = 1'b0;
   localparam arb_id_t ARB_ID_LSU = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/grant memory bus with in-order responses; master drives the request, slave grants and responds.
interface mem_bus_arbiter_if
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW = ARB_AW,
   parameter int DW = ARB_DW
);
   logic            req;
   logic            we;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            gnt;
   logic            rvalid;
   logic [DW-1:0]   rdata;

   modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_bus_arbiter_id_fifo.sv
// In-order master-ID FIFO; head comes straight from the registered read pointer.
// Push is ignored when full and pop is ignored when empty.
module mem_bus_arbiter_id_fifo
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DEPTH = ARB_OUTS_DEPTH
)(
   input  logic    clk,
   input  logic    rstn,
   input  logic    push,
   input  arb_id_t push_id,
   input  logic    pop,
   output arb_id_t head,
   output logic    full,
   output logic    empty
);
   localparam int PW = $clog2(DEPTH);

   arb_id_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/LSU arbiter for one memory port: zero-cycle grant, responses routed in order by an ID FIFO.
// LSU has priority; fetch is forced through after MAX_WAIT denials. Optional stall counters: ARB_STALL_CNT_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW         = ARB_AW,
   parameter int DW         = ARB_DW,
   parameter int OUTS_DEPTH = ARB_OUTS_DEPTH,
   parameter int MAX_WAIT   = ARB_MAX_WAIT
)(
   input  logic        clk,
   input  logic        rstn,
   mem_bus_arbiter_if.slave  m0,
   mem_bus_arbiter_if.slave  m1,
   mem_bus_arbiter_if.master s,
   output logic [31:0] m0_stall_cnt,
   output logic [31:0] m1_stall_cnt
);
   localparam int            WW       = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);

   logic [WW-1:0]   wait_cnt;
   logic            sel_m0;
   logic            sel_m1;
   logic            full;
   logic            empty;
   logic            accept;
   logic            pop;
   arb_id_t         head;
   logic [AW-1:0]   addr_mux;
   logic [DW-1:0]   wdata_mux;
   logic [DW/8-1:0] wstrb_mux;

   always_comb begin
      sel_m0 = m0.req && (!m1.req || wait_cnt == WAIT_TOP);
      sel_m1 = !sel_m0 && m1.req;
   end

   // Fetch is read-only: it never contributes write enable, data or strobes.
   assign addr_mux  = sel_m0 ? m0.addr : (sel_m1 ? m1.addr : '0);
   assign wdata_mux = sel_m1 ? m1.wdata : '0;
   assign wstrb_mux = sel_m1 ? m1.wstrb : '0;

   assign s.req   = (m0.req || m1.req) && !full;
   assign s.we    = sel_m1 && m1.we;
   assign s.addr  = addr_mux;
   assign s.wdata = wdata_mux;
   assign s.wstrb = wstrb_mux;

   assign accept    = s.req && s.gnt;
   assign m0.gnt    = accept && sel_m0;
   assign m1.gnt    = accept && sel_m1;
   assign pop       = s.rvalid && !empty;
   assign m0.rvalid = pop && (head == ARB_ID_IFU);
   assign m1.rvalid = pop && (head == ARB_ID_LSU);
   assign m0.rdata  = s.rdata;
   assign m1.rdata  = s.rdata;

   mem_bus_arbiter_id_fifo #(.DEPTH(OUTS_DEPTH)) u_id_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (accept),
      .push_id (sel_m0 ? ARB_ID_IFU : ARB_ID_LSU),
      .pop     (pop),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   // Holding at the top keeps the override alive across full/!s_gnt stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt <= '0;
      end else if (!m0.req || m0.gnt) begin
         wait_cnt <= '0;
      end else if (m1.req && wait_cnt != WAIT_TOP) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

`ifdef ARB_STALL_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m0_stall_cnt <= '0;
         m1_stall_cnt <= '0;
      end else begin
         if (m0.req && !m0.gnt) m0_stall_cnt <= m0_stall_cnt + 1'b1;
         if (m1.req && !m1.gnt) m1_stall_cnt <= m1_stall_cnt + 1'b1;
      end
   end
`else
   assign m0_stall_cnt = '0;
   assign m1_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (OUTS_DEPTH=2, MAX_WAIT=4): vector table, corner sequences, random traffic.
module tb_mem_bus_arbiter;
   localparam int OD = 2;
   localparam int MW = 4;
`ifdef ARB_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] m0_stall_cnt;
   logic [31:0] m1_stall_cnt;
   int          nchk = 0;
   int          nerr = 0;

   mem_bus_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
   mem_bus_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
   mem_bus_arbiter_if #(.AW(32), .DW(32)) s_bus ();

   mem_bus_arbiter #(.AW(32), .DW(32), .OUTS_DEPTH(OD), .MAX_WAIT(MW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .m0           (m0_bus),
      .m1           (m1_bus),
      .s            (s_bus),
      .m0_stall_cnt (m0_stall_cnt),
      .m1_stall_cnt (m1_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m0r;
      logic [31:0] a0;
      logic        m1r;
      logic        we1;
      logic [31:0] a1;
      logic [31:0] wd1;
      logic [3:0]  ws1;
      logic        sg;
      logic        srv;
      logic [31:0] srd;
      logic        e_g0;
      logic        e_g1;
      logic        e_rv0;
      logic        e_rv1;
      logic        e_sreq;
   } vec_t;

   // Reference model: queue of issuing master IDs, fetch denial count, stall totals.
   int          mq[$];
   int          mwait = 0;
   int unsigned ms0 = 0;
   int unsigned ms1 = 0;

   vec_t tab[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic m0r, input logic [31:0] a0, input logic m1r,
                               input logic we1, input logic [31:0] a1, input logic sg,
                               input logic srv, input logic [31:0] srd, input logic e_g0,
                               input logic e_g1, input logic e_rv0, input logic e_rv1,
                               input logic e_sreq);
      vec_t v;
      v.m0r = m0r; v.a0 = a0; v.m1r = m1r; v.we1 = we1; v.a1 = a1;
      v.wd1 = a1 ^ 32'hA5A5_0000;
      v.ws1 = we1 ? 4'hF : 4'h3;
      v.sg = sg; v.srv = srv; v.srd = srd;
      v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_sreq = e_sreq;
      return v;
   endfunction

   // Drive one cycle at posedge+1, check at the falling edge, advance the model.
   task automatic apply(input vec_t v, input bit use_tab, output bit og0, output bit og1);
      bit full, sel0, sel1, sreq, acc, g0, g1, rv0, rv1;
      m0_bus.req = v.m0r; m0_bus.addr = v.a0; m0_bus.we = 1'b0;
      m0_bus.wdata = '0;  m0_bus.wstrb = '0;
      m1_bus.req = v.m1r; m1_bus.we = v.we1; m1_bus.addr = v.a1;
      m1_bus.wdata = v.wd1; m1_bus.wstrb = v.ws1;
      s_bus.gnt = v.sg; s_bus.rvalid = v.srv; s_bus.rdata = v.srd;
      #4;
      full = (mq.size() == OD);
      sel0 = v.m0r && (!v.m1r || mwait == MW);
      sel1 = !sel0 && v.m1r;
      sreq = (v.m0r || v.m1r) && !full;
      acc  = sreq && v.sg;
      g0   = acc && sel0;
      g1   = acc && sel1;
      rv0  = v.srv && mq.size() > 0 && mq[0] == 0;
      rv1  = v.srv && mq.size() > 0 && mq[0] == 1;
      chk("s_req", s_bus.req, sreq);
      chk("m0_gnt", m0_bus.gnt, g0);
      chk("m1_gnt", m1_bus.gnt, g1);
      chk("m0_rvalid", m0_bus.rvalid, rv0);
      chk("m1_rvalid", m1_bus.rvalid, rv1);
      if (sreq) begin
         chk("s_addr", s_bus.addr, sel0 ? v.a0 : v.a1);
         chk("s_we", s_bus.we, sel1 && v.we1);
         chk("s_wstrb", s_bus.wstrb, sel1 ? v.ws1 : 4'h0);
         if (sel1) chk("s_wdata", s_bus.wdata, v.wd1);
      end
      if (rv0) chk("m0_rdata", m0_bus.rdata, v.srd);
      if (rv1) chk("m1_rdata", m1_bus.rdata, v.srd);
      chk("m0_stall_cnt", m0_stall_cnt, CNT_EN ? 32'(ms0) : 32'd0);
      chk("m1_stall_cnt", m1_stall_cnt, CNT_EN ? 32'(ms1) : 32'd0);
      if (use_tab) begin
         chk("vec_m0_gnt", m0_bus.gnt, v.e_g0);
         chk("vec_m1_gnt", m1_bus.gnt, v.e_g1);
         chk("vec_m0_rvalid", m0_bus.rvalid, v.e_rv0);
         chk("vec_m1_rvalid", m1_bus.rvalid, v.e_rv1);
         chk("vec_s_req", s_bus.req, v.e_sreq);
      end
      if (rv0 || rv1) void'(mq.pop_front());
      if (acc) mq.push_back(sel0 ? 0 : 1);
      if (v.m0r && !g0) ms0++;
      if (v.m1r && !g1) ms1++;
      if (!v.m0r || g0)          mwait = 0;
      else if (v.m1r && mwait < MW) mwait++;
      og0 = g0;
      og1 = g1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      m0_bus.req = 0; m0_bus.addr = '0; m0_bus.we = 0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
      m1_bus.req = 0; m1_bus.addr = '0; m1_bus.we = 0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
      s_bus.gnt = 0; s_bus.rvalid = 0; s_bus.rdata = '0;
      rstn = 1'b0;
      mq.delete();
      mwait = 0; ms0 = 0; ms1 = 0;
      #3;
      chk("rst_s_req", s_bus.req, 0);
      chk("rst_s_addr", s_bus.addr, 0);
      chk("rst_s_we", s_bus.we, 0);
      chk("rst_s_wdata", s_bus.wdata, 0);
      chk("rst_s_wstrb", s_bus.wstrb, 0);
      chk("rst_gnt", {m0_bus.gnt, m1_bus.gnt}, 0);
      chk("rst_rvalid", {m0_bus.rvalid, m1_bus.rvalid}, 0);
      chk("rst_stall_cnt", m0_stall_cnt | m1_stall_cnt, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      bit g0, g1;
      bit p0, p1, w1;
      logic [31:0] ra0, ra1;

      tab[0]  = mk(1, 32'h10,  0, 0, 32'h0,   1, 0, 32'h0,        1, 0, 0, 0, 1);
      tab[1]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h00000013, 0, 0, 1, 0, 0);
      tab[2]  = mk(1, 32'h20,  1, 0, 32'h100, 1, 0, 32'h0,        0, 1, 0, 0, 1);
      tab[3]  = mk(1, 32'h20,  0, 0, 32'h0,   1, 0, 32'h0,        1, 0, 0, 0, 1);
      tab[4]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'hD1,       0, 0, 0, 1, 0);
      tab[5]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'hD0,       0, 0, 1, 0, 0);
      tab[6]  = mk(0, 32'h0,   1, 1, 32'h200, 1, 0, 32'h0,        0, 1, 0, 0, 1);
      tab[7]  = mk(0, 32'h0,   1, 1, 32'h204, 1, 0, 32'h0,        0, 1, 0, 0, 1);
      tab[8]  = mk(0, 32'h0,   1, 1, 32'h208, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tab[9]  = mk(0, 32'h0,   1, 1, 32'h208, 1, 1, 32'hACC0,     0, 0, 0, 1, 0);
      tab[10] = mk(0, 32'h0,   1, 1, 32'h208, 1, 0, 32'h0,        0, 1, 0, 0, 1);
      tab[11] = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'hACC1,     0, 0, 0, 1, 0);
      tab[12] = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'hACC2,     0, 0, 0, 1, 0);
      tab[13] = mk(0, 32'h0,   0, 0, 32'h0,   1, 1, 32'hBAD,      0, 0, 0, 0, 0);

      do_reset();
      for (int i = 0; i < 14; i++) apply(tab[i], 1'b1, g0, g1);

      // Fetch starved by a continuous LSU stream is forced through on the 5th cycle.
      for (int i = 0; i < 6; i++)
         apply(mk(i <= 4, 32'h40, 1, 0, 32'h300, 1, i >= 1, 32'(i),
                  i == 4, i != 4, i == 5, i >= 1 && i != 5, 1), 1'b1, g0, g1);
      apply(mk(0, 0, 0, 0, 0, 1, 1, 32'h55, 0, 0, 0, 1, 0), 1'b1, g0, g1);

      // Outstanding traffic flushed by reset; stale responses must be dropped.
      apply(mk(0, 0,     1, 0, 32'h400, 1, 0, 0, 0, 1, 0, 0, 1), 1'b1, g0, g1);
      apply(mk(1, 32'h44, 0, 0, 0,      1, 0, 0, 1, 0, 0, 0, 1), 1'b1, g0, g1);
      do_reset();
      apply(mk(0, 0, 0, 0, 0,       1, 1, 32'h77, 0, 0, 0, 0, 0), 1'b1, g0, g1);
      apply(mk(0, 0, 1, 1, 32'h500, 1, 0, 0,      0, 1, 0, 0, 1), 1'b1, g0, g1);
      apply(mk(0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 0, 0, 1, 0), 1'b1, g0, g1);

      // LSU held off by the slave for ten cycles.
      do_reset();
      for (int i = 0; i < 10; i++)
         apply(mk(0, 0, 1, 0, 32'h600, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, g0, g1);
      chk("m1_stall_after_10", m1_stall_cnt, CNT_EN ? 32'd10 : 32'd0);
      chk("m0_stall_after_10", m0_stall_cnt, 32'd0);

      // Random traffic; masters keep request and address stable until granted.
      p0 = 0; p1 = 0; w1 = 0; ra0 = '0; ra1 = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!p0 && $urandom_range(0, 1) == 1) begin
            p0 = 1; ra0 = $urandom & 32'hFFFF_FFFC;
         end
         if (!p1 && $urandom_range(0, 3) != 0) begin
            p1 = 1; ra1 = $urandom & 32'hFFFF_FFFC; w1 = $urandom_range(0, 1) == 1;
         end
         apply(mk(p0, ra0, p1, w1, ra1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom, 0, 0, 0, 0, 0), 1'b0, g0, g1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter that shares the core's single memory port between instruction fetch (master 0, read-only) and load/store (master 1, read/write). It sits inside riscv_core between the IFU/LSU and the shared memory.
It tracks outstanding transactions in an in-order ID FIFO so each slave response is routed back to the master that issued it. Fixed LSU priority is used, with an anti-starvation override for fetch.

Parameters:
AW, 32, address width
DW, 32, data width (wstrb width = DW/8)
OUTS_DEPTH, 4, max outstanding slave transactions (power of 2, >=2)
MAX_WAIT, 8, cycles fetch may be denied before forced grant (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
m0_req  in  1  fetch request
m0_addr  in  AW  fetch address
m0_gnt  out  1  fetch request accepted this cycle
m0_rvalid  out  1  fetch response valid
m1_req  in  1  LSU request
m1_we  in  1  LSU write enable
m1_addr  in  AW  LSU address
m1_wdata  in  DW  LSU write data
m1_wstrb  in  DW/8  LSU byte strobes
m1_gnt  out  1  LSU request accepted this cycle
m1_rvalid  out  1  LSU response valid (read data or write ack)
rdata  out  DW  response data, shared by both masters
s_req  out  1  slave request
s_we  out  1  slave write enable
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_wstrb  out  DW/8  slave strobes
s_gnt  in  1  slave accepts request
s_rvalid  in  1  slave response, exactly one per accepted request, in order
s_rdata  in  DW  slave response data
m0_stall_cnt  out  32  feature-gated counter
m1_stall_cnt  out  32  feature-gated counter

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rstn.
- Reset state: ID FIFO empty, wait_cnt=0, counters=0. All outputs are 0 while in reset and with no requests.
- full = (FIFO count == OUTS_DEPTH). A pop in the same cycle does NOT unblock issue; full alone blocks.
- Selection is combinational.
  - sel = M0 if m0_req && (!m1_req || wait_cnt==MAX_WAIT).
  - Otherwise sel = M1 if m1_req.
- s_req = (m0_req|m1_req) && !full. s_we/s_addr/s_wdata/s_wstrb are muxed from sel.
- Fetch drives s_we=0 and s_wstrb=0.
- accept = s_req && s_gnt.
  - m0_gnt = accept && sel==M0; m1_gnt = accept && sel==M1.
  - Zero-cycle grant; a master holds req/addr stable until gnt.
- On accept, push the sel ID (0/1) into the FIFO.
- On s_rvalid with the FIFO non-empty, pop.
  - mN_rvalid = s_rvalid && head==N. rdata = s_rdata passthrough (no added latency).
- s_rvalid with the FIFO empty is a protocol error. It is ignored: no rvalid raised, no pop.
- Push and pop may both occur in the same cycle when not full; count is unchanged.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on cycles with m0_req && !m0_gnt && m1_req.
  - Clears on m0_gnt or !m0_req.
  - Holds otherwise. This includes stalls caused by full or !s_gnt while at MAX_WAIT, so the override persists until fetch is granted.
- Masters must not drop req before gnt. If they do, the arbiter simply re-evaluates; there is no state to unwind.
- Reset mid-operation flushes the FIFO. Any later s_rvalid for pre-reset requests is dropped as an empty-FIFO error.
- The ID FIFO is registered: head is read from the registered read pointer; pointers wrap modulo OUTS_DEPTH.

Optional Feature:
- Macro: ARB_STALL_CNT_EN.
- When defined:
  - m0_stall_cnt increments each cycle m0_req && !m0_gnt.
  - m1_stall_cnt increments each cycle m1_req && !m1_gnt.
  - Both are 32-bit, wrap on overflow, and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package/header (arb_defines): ARB_ID_IFU=0, ARB_ID_LSU=1, ID width=1, and default AW/DW/OUTS_DEPTH/MAX_WAIT.
- One natural sub-module: arb_id_fifo, a synchronous FIFO (width 1, depth OUTS_DEPTH) with push, pop, head, full and empty outputs, on the same clk/rstn.

Test Plan:
- Single fetch: m0_req with m0_addr=0x10, s_gnt=1; slave returns s_rvalid next cycle with s_rdata=0x00000013 -> m0_gnt=1 in the request cycle; one cycle later m0_rvalid=1, rdata=0x00000013, m1_rvalid=0.
- Simultaneous requests: m0_req and m1_req (read 0x100) in the same cycle -> m1_gnt first, m0_gnt the next cycle; responses D1 then D0 give m1_rvalid then m0_rvalid, in order.
- Starvation (MAX_WAIT=4): m1_req held high continuously, m0_req high from cycle 0 -> m0 denied for 4 cycles, m0_gnt=1 in the 5th cycle, wait_cnt back to 0, then m1 granted again.
- Outstanding limit (OUTS_DEPTH=2): s_gnt=1, s_rvalid held low -> two grants, then s_req=0 and no gnt; the first s_rvalid pops one entry and a grant resumes the following cycle.
- Reset/error: two transactions outstanding, rstn pulsed low, then s_rvalid=1 -> m0_rvalid=m1_rvalid=0 and FIFO stays empty; a fresh m1 write afterwards gets its ack on m1_rvalid.
- ARB_STALL_CNT_EN: hold m1_req with s_gnt=0 for 10 cycles -> m1_stall_cnt=10 and m0_stall_cnt=0; without the macro both read 0.
